// File: rtl/op_select_input.sv
// Op-select input stage: synchronizes and debounces the op switches and confirm button,
// then validates a one-hot op choice while the calculator FSM sits in its op-select state.
module op_select_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned SEC_CYCLES      = 100_000_000,
  parameter int unsigned TIMEOUT_S       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [3:0] sw,
  input  logic       btn_confirm,
  output logic [3:0] op_type,
  output logic       op_valid,
  output logic       op_error,
  output logic       timeout,
  output logic [3:0] sec_left
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SEC_W = $clog2(SEC_CYCLES + 1);
  localparam logic [3:0]  OP_STATE = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  // Two-flop synchronizers for the raw switch and button inputs
  logic [3:0] sw_meta, sw_sync;
  logic       btn_meta, btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn_confirm;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: the filtered value follows only after DEBOUNCE_CYCLES consecutive differing cycles
  logic [3:0]      sw_db;
  logic [DB_W-1:0] sw_cnt;
  logic            btn_db, btn_db_q;
  logic [DB_W-1:0] btn_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_db    <= '0;
      sw_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      btn_cnt  <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (sw_sync != sw_db) begin
        if (sw_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          sw_db  <= sw_sync;
          sw_cnt <= '0;
        end else begin
          sw_cnt <= sw_cnt + DB_W'(1);
        end
      end else begin
        sw_cnt <= '0;
      end
      if (btn_sync != btn_db) begin
        if (btn_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db  <= btn_sync;
          btn_cnt <= '0;
        end else begin
          btn_cnt <= btn_cnt + DB_W'(1);
        end
      end else begin
        btn_cnt <= '0;
      end
    end
  end

  logic press;
  logic sw_onehot;
  assign press     = btn_db & ~btn_db_q;
  assign sw_onehot = $onehot(sw_db);

  fsm_t             fsm_q, fsm_d;
  logic [SEC_W-1:0] sec_cnt, sec_cnt_d;
  logic [3:0]       op_type_d, sec_left_d;
  logic             op_valid_d, op_error_d, timeout_d;
  logic             tick;

  assign tick = (sec_cnt == SEC_W'(SEC_CYCLES - 1));

  // Control state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      sec_cnt  <= '0;
      op_type  <= '0;
      sec_left <= '0;
      op_valid <= 1'b0;
      op_error <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      sec_cnt  <= sec_cnt_d;
      op_type  <= op_type_d;
      sec_left <= sec_left_d;
      op_valid <= op_valid_d;
      op_error <= op_error_d;
      timeout  <= timeout_d;
    end
  end

  // Next state; leaving op-select overrides any press or tick in the same cycle
  always_comb begin
    fsm_d      = fsm_q;
    sec_cnt_d  = sec_cnt;
    op_type_d  = op_type;
    sec_left_d = sec_left;
    op_valid_d = 1'b0;
    op_error_d = 1'b0;
    timeout_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (state == OP_STATE) begin
          fsm_d      = S_ARMED;
          sec_left_d = 4'(TIMEOUT_S);
          sec_cnt_d  = '0;
        end
      end
      S_ARMED: begin
        if (state != OP_STATE) begin
          fsm_d      = S_IDLE;
          sec_left_d = '0;
        end else begin
          sec_cnt_d = tick ? '0 : sec_cnt + SEC_W'(1);
          if (press && sw_onehot) begin
            op_type_d  = sw_db;
            op_valid_d = 1'b1;
            fsm_d      = S_DONE;
          end else begin
            op_error_d = press;
            if (tick) begin
              sec_left_d = sec_left - 4'd1;
              if (sec_left == 4'd1) begin
                timeout_d = 1'b1;
                fsm_d     = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        if (state != OP_STATE) begin
          fsm_d      = S_IDLE;
          sec_left_d = '0;
        end
      end
      default: begin
        fsm_d      = S_IDLE;
        sec_left_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_op_select_input.sv
// Bench for op_select_input: directed table, hand sequences for timing corners, and a
// random run checked every cycle against a behavioural model.
module tb_op_select_input;

  localparam int DB  = 4;
  localparam int SEC = 16;
  localparam int TO  = 3;

  logic       clk, rst_n;
  logic [3:0] state, sw;
  logic       btn_confirm;
  logic [3:0] op_type, sec_left;
  logic       op_valid, op_error, timeout;

  op_select_input #(
    .DEBOUNCE_CYCLES(DB),
    .SEC_CYCLES     (SEC),
    .TIMEOUT_S      (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .sw         (sw),
    .btn_confirm(btn_confirm),
    .op_type    (op_type),
    .op_valid   (op_valid),
    .op_error   (op_error),
    .timeout    (timeout),
    .sec_left   (sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid, n_err, n_to;

  // Behavioural model: raw-input history, debounced values, and time spent armed
  logic [3:0] sw_pipe[$];
  logic       btn_pipe[$];
  logic [3:0] m_sw_db, m_op, m_sec;
  logic       m_btn_db, m_btn_prev, m_v, m_e, m_t;
  int         m_sw_run, m_btn_run, m_mode, m_elapsed;

  task automatic model_reset();
    sw_pipe.delete();  sw_pipe.push_back(4'd0);  sw_pipe.push_back(4'd0);
    btn_pipe.delete(); btn_pipe.push_back(1'b0); btn_pipe.push_back(1'b0);
    m_sw_db = '0; m_btn_db = 1'b0; m_btn_prev = 1'b0;
    m_sw_run = 0; m_btn_run = 0;
    m_mode = 0; m_elapsed = 0;
    m_op = '0; m_sec = '0; m_v = 1'b0; m_e = 1'b0; m_t = 1'b0;
  endtask

  task automatic model_step();
    logic       press, onehot, s_btn;
    logic [3:0] s_sw;
    int         rem;
    press  = m_btn_db && !m_btn_prev;
    onehot = ($countones(m_sw_db) == 1);
    m_v = 1'b0; m_e = 1'b0; m_t = 1'b0;
    if (m_mode == 0) begin
      if (state == 4'd8) begin m_mode = 1; m_elapsed = 0; m_sec = 4'(TO); end
    end else if (state != 4'd8) begin
      m_mode = 0; m_sec = '0;
    end else if (m_mode == 1) begin
      m_elapsed++;
      rem = TO - m_elapsed / SEC;
      if (press && onehot) begin
        m_op = m_sw_db; m_v = 1'b1; m_mode = 2;
      end else begin
        m_sec = 4'(rem);
        m_e   = press;
        if (rem == 0) begin m_t = 1'b1; m_mode = 2; end
      end
    end
    s_sw  = sw_pipe[0];
    s_btn = btn_pipe[0];
    m_btn_prev = m_btn_db;
    if (s_sw != m_sw_db) begin
      m_sw_run++;
      if (m_sw_run == DB) begin m_sw_db = s_sw; m_sw_run = 0; end
    end else m_sw_run = 0;
    if (s_btn != m_btn_db) begin
      m_btn_run++;
      if (m_btn_run == DB) begin m_btn_db = s_btn; m_btn_run = 0; end
    end else m_btn_run = 0;
    void'(sw_pipe.pop_front());  sw_pipe.push_back(sw);
    void'(btn_pipe.pop_front()); btn_pipe.push_back(btn_confirm);
  endtask

  task automatic cmp_model();
    logic [14:0] got, exp;
    got = {op_type, op_valid, op_error, timeout, sec_left};
    exp = {m_op, m_v, m_e, m_t, m_sec};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t got op_type=%b v=%b e=%b to=%b sec=%0d want op_type=%b v=%b e=%b to=%b sec=%0d",
               $time, op_type, op_valid, op_error, timeout, sec_left, m_op, m_v, m_e, m_t, m_sec);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // One clock: advance the model at the edge, compare and tally pulses on the falling edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      cmp_model();
      if (op_valid) n_valid++;
      if (op_error) n_err++;
      if (timeout)  n_to++;
    end
  endtask

  task automatic clr();
    n_valid = 0; n_err = 0; n_to = 0;
  endtask

  typedef struct {
    logic [3:0] sw;
    int         exp_v;
    int         exp_e;
    logic [3:0] exp_op;
  } vec_t;

  vec_t tbl[8];
  int   vidx, tidx;

  initial begin
    tbl[0] = '{4'b0001, 1, 0, 4'b0001};
    tbl[1] = '{4'b0010, 1, 0, 4'b0010};
    tbl[2] = '{4'b0100, 1, 0, 4'b0100};
    tbl[3] = '{4'b1000, 1, 0, 4'b1000};
    tbl[4] = '{4'b0000, 0, 1, 4'b1000};
    tbl[5] = '{4'b0110, 0, 1, 4'b1000};
    tbl[6] = '{4'b1111, 0, 1, 4'b1000};
    tbl[7] = '{4'b1001, 0, 1, 4'b1000};

    model_reset();
    clr();
    rst_n = 1'b0;
    state = 4'($urandom); sw = 4'($urandom); btn_confirm = 1'($urandom);
    cyc(3);
    chk("rst_op_type", int'(op_type), 0);
    chk("rst_pulses", int'({op_valid, op_error, timeout}), 0);
    chk("rst_sec_left", int'(sec_left), 0);
    state = 4'd0; sw = 4'd0; btn_confirm = 1'b0; rst_n = 1'b1;
    cyc(6);
    chk("idle_sec_left", int'(sec_left), 0);
    chk("idle_pulses", n_valid + n_err + n_to, 0);

    // Table: settle sw, arm, press, count pulses
    for (int k = 0; k < 8; k++) begin
      state = 4'd0; btn_confirm = 1'b0; cyc(2);
      sw = tbl[k].sw; cyc(8);
      state = 4'd8; cyc(1);
      clr();
      btn_confirm = 1'b1; cyc(10);
      btn_confirm = 1'b0; cyc(6);
      chk($sformatf("tbl%0d_valid", k), n_valid, tbl[k].exp_v);
      chk($sformatf("tbl%0d_error", k), n_err, tbl[k].exp_e);
      chk($sformatf("tbl%0d_op_type", k), int'(op_type), int'(tbl[k].exp_op));
    end

    // Press-to-valid latency, then a second press in DONE
    state = 4'd0; cyc(2);
    sw = 4'b0100; cyc(8);
    state = 4'd8; cyc(1);
    clr(); vidx = -1;
    btn_confirm = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (op_valid && vidx < 0) vidx = i;
    end
    chk("lat_valid_cycle", vidx, 7);
    chk("lat_valid_count", n_valid, 1);
    chk("lat_op_type", int'(op_type), 4);
    btn_confirm = 1'b0; cyc(6);
    clr();
    btn_confirm = 1'b1; cyc(10);
    btn_confirm = 1'b0; cyc(6);
    chk("done_press_pulses", n_valid + n_err + n_to, 0);

    // Countdown to timeout
    state = 4'd0; cyc(2);
    state = 4'd8; cyc(1);
    chk("to_entry_sec", int'(sec_left), 3);
    clr(); tidx = -1;
    for (int i = 1; i <= 48; i++) begin
      cyc(1);
      if (timeout && tidx < 0) tidx = i;
      if (i == 15) chk("to_sec_15", int'(sec_left), 3);
      if (i == 16) chk("to_sec_16", int'(sec_left), 2);
      if (i == 32) chk("to_sec_32", int'(sec_left), 1);
      if (i == 48) chk("to_sec_48", int'(sec_left), 0);
    end
    cyc(5);
    chk("to_cycle", tidx, 48);
    chk("to_count", n_to, 1);
    state = 4'd0; cyc(1);
    state = 4'd8; cyc(1);
    chk("to_reentry_sec", int'(sec_left), 3);

    // Abort while armed at sec_left=2
    cyc(16);
    chk("abort_pre_sec", int'(sec_left), 2);
    clr();
    state = 4'd0; cyc(1);
    chk("abort_sec", int'(sec_left), 0);
    chk("abort_pulses", n_valid + n_err + n_to, 0);

    // Bouncing button, then held
    sw = 4'b1000; cyc(8);
    state = 4'd8; cyc(1);
    clr();
    for (int i = 0; i < 10; i++) begin
      btn_confirm = ~btn_confirm; cyc(2);
    end
    btn_confirm = 1'b1; cyc(12);
    chk("bounce_valid_count", n_valid, 1);
    chk("bounce_op_type", int'(op_type), 8);

    // Asynchronous reset mid-ARMED
    btn_confirm = 1'b0; state = 4'd0; cyc(6);
    state = 4'd8; cyc(3);
    chk("ares_pre_sec", int'(sec_left), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ares_op_type", int'(op_type), 0);
    chk("ares_sec_left", int'(sec_left), 0);
    chk("ares_pulses", int'({op_valid, op_error, timeout}), 0);
    model_reset();
    cyc(2);
    rst_n = 1'b1;

    // Random run against the model
    state = 4'd8;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) state = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd8;
      if ($urandom_range(9) == 0) sw = 4'($urandom);
      if ($urandom_range(5) == 0) btn_confirm = ~btn_confirm;
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
